// File: rtl/booth_mult_seq.sv
// Sequential signed 32x32 radix-2 Booth multiplier with a 32-bit carry-lookahead adder.
// Optional macro MULT_HI_EN adds data_result_hi carrying product bits 63:32.

module cla_adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c0,
  output logic [31:0] s,
  output logic        overflow
);
  logic [31:0] g;
  logic [31:0] p;
  logic [3:0]  gg;
  logic [3:0]  pp;
  logic [4:0]  cc;
  logic        cin;
  logic        c31;

  assign g = a & b;
  assign p = a ^ b;

  // Eight 4-bit lookahead groups; the group carry chain is evaluated in one block.
  always_comb begin
    s   = '0;
    cin = c0;
    c31 = 1'b0;
    gg  = '0;
    pp  = '0;
    cc  = '0;
    for (int k = 0; k < 8; k++) begin
      gg    = g[4*k +: 4];
      pp    = p[4*k +: 4];
      cc[0] = cin;
      cc[1] = gg[0] | (pp[0] & cin);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & cin);
      cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cin);
      s[4*k +: 4] = pp ^ cc[3:0];
      if (k == 7) c31 = cc[3];
      cin = cc[4];
    end
    overflow = c31 ^ cin;
  end
endmodule

module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
`ifdef MULT_HI_EN
  output logic             busy,
  output logic [WIDTH-1:0] data_result_hi
`else
  output logic             busy
`endif
);
  // Handshake: ctrl_MULT is a start strobe accepted on any edge; data_resultRDY
  // pulses for exactly one cycle with data_result/data_exception valid from then on.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             q_m1;
  logic [5:0]       count;

  logic [1:0]       pair;
  logic             do_sub;
  logic [WIDTH-1:0] adder_b;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             exc_n;

  cla_adder_32 u_adder (
    .a        (acc[WIDTH-1:0]),
    .b        (adder_b),
    .c0       (do_sub),
    .s        (sum),
    .overflow (ovf)
  );

  // Acc[32] comes from the true 33-bit sum sign so M = -2^31 is handled exactly.
  always_comb begin
    pair    = {q[0], q_m1};
    do_sub  = (pair == 2'b10);
    adder_b = do_sub ? ~m : m;
    acc_n   = acc;
    if (pair == 2'b01 || pair == 2'b10) acc_n = {sum[WIDTH-1] ^ ovf, sum};
    acc_sh  = {acc_n[WIDTH], acc_n[WIDTH:1]};
    q_sh    = {acc_n[0], q[WIDTH-1:1]};
    exc_n   = ~((&{acc_sh[WIDTH-1:0], q_sh[WIDTH-1]}) | ~(|{acc_sh[WIDTH-1:0], q_sh[WIDTH-1]}));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      acc            <= '0;
      q              <= '0;
      m              <= '0;
      q_m1           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
`ifdef MULT_HI_EN
      data_result_hi <= '0;
`endif
    end else if (ctrl_MULT) begin
      m              <= data_operandA;
      q              <= data_operandB;
      acc            <= '0;
      q_m1           <= 1'b0;
      count          <= '0;
      state          <= RUN;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
        RUN: begin
          acc   <= acc_sh;
          q     <= q_sh;
          q_m1  <= q[0];
          count <= count + 6'd1;
          if (count == 6'(STEPS - 1)) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= q_sh;
            data_exception <= exc_n;
`ifdef MULT_HI_EN
            data_result_hi <= acc_sh[WIDTH-1:0];
`endif
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq: vector table plus restart, reset and hold sequences.

module tb_booth_mult_seq;
  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef MULT_HI_EN
  logic [31:0] data_result_hi;
`endif

  int checks;
  int errors;
  int busy_cnt;
  int rdy_cnt;
  int lat;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic        exc;
  } vec_t;

  vec_t vecs [12];

  booth_mult_seq dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef MULT_HI_EN
    .busy           (busy),
    .data_result_hi (data_result_hi)
`else
    .busy           (busy)
`endif
  );

  // Clock and monitors
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (data_resultRDY) rdy_cnt++;
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    busy_cnt = 0;
    rdy_cnt  = 0;
    tick();
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    tick();
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Counts edges after the start edge until RDY; 40 means it never came.
  task automatic wait_rdy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      n++;
      if (data_resultRDY) break;
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    busy_cnt      = 0;
    rdy_cnt       = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs[0]  = '{32'd7,        32'd6,        32'd42,       32'h0,        1'b0};
    vecs[1]  = '{-32'sd3,      32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{-32'sd4,      -32'sd8,      32'd32,       32'h0,        1'b0};
    vecs[3]  = '{32'h80000000, 32'd1,        32'h80000000, 32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b1};
    vecs[5]  = '{32'h00010000, 32'h00010000, 32'h0,        32'h1,        1'b1};
    vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0};
    vecs[7]  = '{32'h0,        32'h12345678, 32'h0,        32'h0,        1'b0};
    vecs[8]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h1,        32'h3FFFFFFF, 1'b1};
    vecs[9]  = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h0,        1'b1};
    vecs[10] = '{32'h00010000, 32'h00007FFF, 32'h7FFF0000, 32'h0,        1'b0};
    vecs[11] = '{32'hFFFF0000, 32'h00008000, 32'h80000000, 32'hFFFFFFFF, 1'b0};

    // Reset state
    repeat (2) tick();
    check("reset_result", data_result, 32'h0);
    check("reset_exc", {31'h0, data_exception}, 32'h0);
    check("reset_rdy", {31'h0, data_resultRDY}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
`ifdef MULT_HI_EN
    check("reset_hi", data_result_hi, 32'h0);
`endif
    reset = 1'b0;
    tick();

    // Table of directed products
    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_rdy(lat);
      check($sformatf("v%0d_latency", i), lat, 32'd32);
      check($sformatf("v%0d_result", i), data_result, vecs[i].res);
      check($sformatf("v%0d_exc", i), {31'h0, data_exception}, {31'h0, vecs[i].exc});
`ifdef MULT_HI_EN
      check($sformatf("v%0d_hi", i), data_result_hi, vecs[i].hi);
`endif
      tick();
      check($sformatf("v%0d_rdy_drop", i), {31'h0, data_resultRDY}, 32'h0);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, 32'd32);
      check($sformatf("v%0d_rdy_cycles", i), rdy_cnt, 32'd1);
    end

    // Hold after 7*6
    start_op(32'd7, 32'd6);
    wait_rdy(lat);
    tick();
    rdy_cnt = 0;
    repeat (20) tick();
    check("hold_result", data_result, 32'd42);
    check("hold_exc", {31'h0, data_exception}, 32'h0);
    check("hold_no_rdy", rdy_cnt, 32'd0);

    // ctrl_MULT held high keeps restarting
    rdy_cnt = 0;
    tick();
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd5;
    repeat (10) tick();
    check("held_busy", {31'h0, busy}, 32'h1);
    check("held_no_rdy", rdy_cnt, 32'd0);
    ctrl_MULT = 1'b0;
    wait_rdy(lat);
    check("held_latency", lat, 32'd32);
    check("held_result", data_result, 32'd10);
    tick();

    // Restart mid-run: only the second operation reports
    start_op(32'd3, 32'd3);
    repeat (8) tick();
    start_op(32'd2, 32'd9);
    wait_rdy(lat);
    check("restart_latency", lat, 32'd32);
    check("restart_result", data_result, 32'd18);
    repeat (5) tick();
    check("restart_rdy_cycles", rdy_cnt, 32'd1);

    // Reset mid-run clears outputs and suppresses RDY
    start_op(32'd5, 32'd5);
    repeat (13) tick();
    reset = 1'b1;
    tick();
    check("midreset_result", data_result, 32'h0);
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_rdy", {31'h0, data_resultRDY}, 32'h0);
    reset = 1'b0;
    repeat (40) tick();
    check("midreset_no_rdy", rdy_cnt, 32'd0);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_rdy(lat);
    check("after_reset_latency", lat, 32'd32);
    check("after_reset_result", data_result, 32'd1);
    check("after_reset_exc", {31'h0, data_exception}, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
